// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller for the M stage: SR/Cause/EPC, exception/interrupt arbitration, mfc0/mtc0/eret.
// Optional BadVAddr register (reg 8) is enabled by defining CP0_BADVADDR_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2023,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  M_excCode,
    input  logic [31:0] M_pc,
    input  logic        M_bd,
    input  logic [5:0]  HWInt,
    input  logic        M_mtc0,
    input  logic        M_eret,
    input  logic [4:0]  M_addr,
    input  logic [31:0] M_wdata,
    input  logic [31:0] M_vaddr,
    output logic [31:0] M_rdata,
    output logic        req,
    output logic [31:0] req_pc,
    output logic [31:0] EPC_out
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] badvaddr_word;

    // EXL masks both sources; an interrupt takes priority over a pending exception code.
    assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (M_excCode != 5'd0) & ~sr_exl;
    assign req     = int_req | exc_req;
    assign req_pc  = req ? HANDLER_PC : epc;
    assign EPC_out = epc;

    // A taken exception squashes the mtc0/eret sitting in M.
    assign wr_sr    = M_mtc0 & ~req & (M_addr == REG_SR);
    assign wr_epc   = M_mtc0 & ~req & (M_addr == REG_EPC);
    assign epc_next = M_bd ? (M_pc - 32'd4) : M_pc;

    assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= HWInt;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : M_excCode;
                cause_bd  <= M_bd;
                epc       <= epc_next;
            end else begin
                if (wr_sr) begin
                    sr_im  <= M_wdata[15:10];
                    sr_exl <= M_wdata[1];
                    sr_ie  <= M_wdata[0];
                end else if (M_eret) begin
                    sr_exl <= 1'b0;
                end
                if (wr_epc) begin
                    epc <= M_wdata;
                end
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    // Only address-error exceptions that actually win arbitration capture the faulting address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            badvaddr <= 32'd0;
        end else if (exc_req && !int_req &&
                     (M_excCode == EXC_ADEL || M_excCode == EXC_ADES)) begin
            badvaddr <= M_vaddr;
        end
    end

    assign badvaddr_word = badvaddr;
`else
    logic unused_vaddr;

    assign unused_vaddr  = ^{M_vaddr, EXC_ADEL, EXC_ADES};
    assign badvaddr_word = 32'd0;
`endif

    always_comb begin
        M_rdata = 32'd0;
        case (M_addr)
            REG_BADVADDR: M_rdata = badvaddr_word;
            REG_SR:       M_rdata = sr_word;
            REG_CAUSE:    M_rdata = cause_word;
            REG_EPC:      M_rdata = epc;
            REG_PRID:     M_rdata = PRID_VALUE;
            default:      M_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  M_excCode;
    logic [31:0] M_pc;
    logic        M_bd;
    logic [5:0]  HWInt;
    logic        M_mtc0;
    logic        M_eret;
    logic [4:0]  M_addr;
    logic [31:0] M_wdata;
    logic [31:0] M_vaddr;
    logic [31:0] M_rdata;
    logic        req;
    logic [31:0] req_pc;
    logic [31:0] EPC_out;

    localparam int SEL_REQ   = 0;
    localparam int SEL_REQPC = 1;
    localparam int SEL_RDATA = 2;
    localparam int SEL_EPC   = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   stim_done = 1'b0;

    cp0_exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .M_excCode (M_excCode),
        .M_pc      (M_pc),
        .M_bd      (M_bd),
        .HWInt     (HWInt),
        .M_mtc0    (M_mtc0),
        .M_eret    (M_eret),
        .M_addr    (M_addr),
        .M_wdata   (M_wdata),
        .M_vaddr   (M_vaddr),
        .M_rdata   (M_rdata),
        .req       (req),
        .req_pc    (req_pc),
        .EPC_out   (EPC_out)
    );

    always #5 clk = ~clk;

    function automatic void push_exp(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endfunction

    // Monitor: every negedge, compare all expectations queued for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                SEL_REQ:   act = {31'd0, req};
                SEL_REQPC: act = req_pc;
                SEL_RDATA: act = M_rdata;
                default:   act = EPC_out;
            endcase
            n_total++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got 32'h%08h, expected 32'h%08h", e.name, act, e.val);
        end
    end

    // Applies one cycle of M-stage inputs just after the rising edge.
    task automatic drive(input logic rst_n, input logic [4:0] exc, input logic [31:0] pc,
                         input logic bd, input logic [5:0] hw, input logic mtc0,
                         input logic eret, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] vaddr);
        @(posedge clk);
        #1;
        reset     = rst_n;
        M_excCode = exc;
        M_pc      = pc;
        M_bd      = bd;
        HWInt     = hw;
        M_mtc0    = mtc0;
        M_eret    = eret;
        M_addr    = addr;
        M_wdata   = wdata;
        M_vaddr   = vaddr;
    endtask

    task automatic rd(input logic [5:0] hw, input logic [4:0] addr, input logic [31:0] val,
                      input string name);
        drive(1'b1, 5'd0, 32'd0, 1'b0, hw, 1'b0, 1'b0, addr, 32'd0, 32'd0);
        push_exp(name, SEL_RDATA, val);
    endtask

    initial begin
        reset = 1'b0; M_excCode = 5'd0; M_pc = 32'd0; M_bd = 1'b0; HWInt = 6'h3F;
        M_mtc0 = 1'b0; M_eret = 1'b0; M_addr = 5'd0; M_wdata = 32'd0; M_vaddr = 32'd0;

        // Reset for two cycles with all interrupt lines high
        drive(1'b0, 5'd0, 32'd0, 1'b0, 6'h3F, 1'b0, 1'b0, 5'd12, 32'd0, 32'd0);
        push_exp("rst_req", SEL_REQ, 32'd0);
        push_exp("rst_sr", SEL_RDATA, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 6'h3F, 1'b0, 1'b0, 5'd13, 32'd0, 32'd0);
        push_exp("rst_cause", SEL_RDATA, 32'd0);
        push_exp("rst_epc", SEL_EPC, 32'd0);
        rd(6'h3F, 5'd14, 32'd0, "rst_epc_rd");
        push_exp("rst_req_after", SEL_REQ, 32'd0);
        rd(6'h00, 5'd13, 32'h0000_FC00, "cause_ip_3f");

        // Overflow exception, not in a delay slot
        drive(1'b1, 5'd12, 32'h3010, 1'b0, 6'h00, 1'b0, 1'b0, 5'd14, 32'd0, 32'd0);
        push_exp("ov_req", SEL_REQ, 32'd1);
        push_exp("ov_req_pc", SEL_REQPC, 32'h4180);
        push_exp("ov_epc_old", SEL_RDATA, 32'd0);
        rd(6'h00, 5'd14, 32'h3010, "ov_epc");
        push_exp("ov_epc_out", SEL_EPC, 32'h3010);
        push_exp("exl_masks_req", SEL_REQ, 32'd0);
        rd(6'h00, 5'd13, 32'h0000_0030, "ov_cause");
        rd(6'h00, 5'd12, 32'h0000_0002, "ov_sr_exl");

        // Interrupt beats a simultaneous AdEL in a delay slot
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b1, 1'b0, 5'd12, 32'h0000_0401, 32'd0);
        push_exp("mtc0_sr_req", SEL_REQ, 32'd0);
        drive(1'b1, 5'd4, 32'h3100, 1'b1, 6'h01, 1'b0, 1'b0, 5'd12, 32'd0, 32'd0);
        push_exp("mtc0_sr_rd", SEL_RDATA, 32'h0000_0401);
        push_exp("int_req", SEL_REQ, 32'd1);
        push_exp("int_req_pc", SEL_REQPC, 32'h4180);
        rd(6'h00, 5'd13, 32'h8000_0400, "int_cause");
        push_exp("int_epc_bd", SEL_EPC, 32'h30FC);
        rd(6'h00, 5'd12, 32'h0000_0403, "int_sr");

        // EXL set: AdES and an active interrupt line are both ignored
        drive(1'b1, 5'd5, 32'h3300, 1'b0, 6'h01, 1'b0, 1'b0, 5'd14, 32'd0, 32'd0);
        push_exp("exl_ades_req", SEL_REQ, 32'd0);
        push_exp("exl_req_pc", SEL_REQPC, 32'h30FC);
        rd(6'h00, 5'd14, 32'h30FC, "exl_epc_kept");
        rd(6'h00, 5'd13, 32'h8000_0000, "exl_cause_kept");

        // eret: target is EPC, EXL clears next cycle
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0);
        push_exp("eret_req", SEL_REQ, 32'd0);
        push_exp("eret_req_pc", SEL_REQPC, 32'h30FC);
        rd(6'h00, 5'd12, 32'h0000_0401, "eret_sr");

        // mtc0 EPC loses to a simultaneous RI exception
        drive(1'b1, 5'd10, 32'h3200, 1'b0, 6'h00, 1'b1, 1'b0, 5'd14, 32'h3abc, 32'd0);
        push_exp("ri_req", SEL_REQ, 32'd1);
        rd(6'h00, 5'd14, 32'h3200, "ri_epc");
        rd(6'h00, 5'd13, 32'h0000_0028, "ri_cause");
        rd(6'h00, 5'd15, 32'h0000_2023, "prid");
        rd(6'h00, 5'd3, 32'h0000_0000, "unmapped_reg");

        // Cause is read-only; EPC writable when nothing is taken
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 32'd0);
        rd(6'h00, 5'd13, 32'h0000_0028, "cause_ro");
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0);
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b1, 1'b0, 5'd14, 32'h3abc, 32'd0);
        push_exp("mtc0_epc_req", SEL_REQ, 32'd0);
        rd(6'h00, 5'd14, 32'h3abc, "mtc0_epc");

        // Syscall in a delay slot at PC 0: EPC wraps
        drive(1'b1, 5'd8, 32'd0, 1'b1, 6'h00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        push_exp("sys_req", SEL_REQ, 32'd1);
        rd(6'h00, 5'd14, 32'hFFFF_FFFC, "sys_epc_wrap");
        rd(6'h00, 5'd13, 32'h8000_0020, "sys_cause");

        // Reset asserted in the same cycle as a taken exception
        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0);
        drive(1'b0, 5'd12, 32'h3400, 1'b0, 6'h00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        push_exp("rst_mid_req", SEL_REQ, 32'd1);
        rd(6'h00, 5'd14, 32'd0, "rst_mid_epc");
        rd(6'h00, 5'd12, 32'd0, "rst_mid_sr");
        rd(6'h00, 5'd13, 32'd0, "rst_mid_cause");

        // AdEL with a faulting address, then read reg 8
        drive(1'b1, 5'd4, 32'h3500, 1'b0, 6'h00, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_7F01);
        push_exp("adel_req", SEL_REQ, 32'd1);
`ifdef CP0_BADVADDR_EN
        rd(6'h00, 5'd8, 32'h0000_7F01, "badvaddr");
`else
        rd(6'h00, 5'd8, 32'h0000_0000, "badvaddr_absent");
`endif
        rd(6'h00, 5'd13, 32'h0000_0010, "adel_cause");

        drive(1'b1, 5'd0, 32'd0, 1'b0, 6'h00, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        stim_done = 1'b1;
    end

    initial begin
        int waited;
        waited = 0;
        while (!(stim_done && q.size() == 0) && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            n_total++;
            $display("FAIL timeout: got %0d pending expectations, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
